// File: rtl/branch_redirect_unit.sv
// Turns resolved taken branches and jumps from decode into a registered fetch redirect.
// It holds the redirect under valid/ready, pulses an IF/ID flush, and counts resolved and taken branches.
module branch_redirect_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [15:0]       br_imm,
   input  logic              bcres,
   input  logic              is_jump,
   input  logic [25:0]       jidx,
   output logic              redir_valid,
   output logic [ADDR_W-1:0] redir_pc,
   input  logic              redir_ready,
   output logic              flush,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t            state, state_n;
   logic              redir_valid_n, flush_n;
   logic [ADDR_W-1:0] redir_pc_n;
   logic [CNT_W-1:0]  br_cnt_n, taken_cnt_n;

   logic [ADDR_W-1:0] pc4, br_off, br_tgt, jmp_tgt, tgt;
   logic              take;

   // Target generation; the jump keeps the 256 MB region of the delay-slot-free pc4
   assign pc4     = br_pc + ADDR_W'(4);
   assign br_off  = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
   assign br_tgt  = pc4 + br_off;
   assign jmp_tgt = {pc4[ADDR_W-1:28], jidx, 2'b00};
   assign tgt     = is_jump ? jmp_tgt : br_tgt;
   assign take    = br_valid & (is_jump | bcres);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
         flush       <= 1'b0;
         br_cnt      <= '0;
         taken_cnt   <= '0;
      end else begin
         state       <= state_n;
         redir_valid <= redir_valid_n;
         redir_pc    <= redir_pc_n;
         flush       <= flush_n;
         br_cnt      <= br_cnt_n;
         taken_cnt   <= taken_cnt_n;
      end
   end

   // Branches seen while WAIT is pending are on the squashed path and are dropped
   always_comb begin
      state_n       = state;
      redir_valid_n = redir_valid;
      redir_pc_n    = redir_pc;
      flush_n       = 1'b0;
      br_cnt_n      = br_cnt;
      taken_cnt_n   = taken_cnt;
      case (state)
         IDLE: begin
            if (br_valid) br_cnt_n = br_cnt + CNT_W'(1);
            if (take) begin
               redir_pc_n    = tgt;
               redir_valid_n = 1'b1;
               flush_n       = 1'b1;
               taken_cnt_n   = taken_cnt + CNT_W'(1);
               state_n       = WAIT;
            end
         end
         WAIT: begin
            if (redir_ready) begin
               redir_valid_n = 1'b0;
               state_n       = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit with hand-computed expected values.
// It uses CNT_W=4 so that the counter wrap can be reached in a few cycles.
module tb_branch_redirect_unit;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              br_valid = 1'b0;
   logic [ADDR_W-1:0] br_pc = '0;
   logic [15:0]       br_imm = '0;
   logic              bcres = 1'b0;
   logic              is_jump = 1'b0;
   logic [25:0]       jidx = '0;
   logic              redir_valid;
   logic [ADDR_W-1:0] redir_pc;
   logic              redir_ready = 1'b0;
   logic              flush;
   logic [CNT_W-1:0]  br_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   int checks = 0;
   int failures = 0;

   branch_redirect_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc), .br_imm(br_imm),
      .bcres(bcres), .is_jump(is_jump), .jidx(jidx), .redir_valid(redir_valid),
      .redir_pc(redir_pc), .redir_ready(redir_ready), .flush(flush),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      br_valid = 1'b0; bcres = 1'b0; is_jump = 1'b0; redir_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({redir_valid, flush, br_cnt, taken_cnt, redir_pc} !== '0) begin
         failures++;
         $display("FAIL reset_state: valid=%b flush=%b br=%0d tk=%0d pc=%h required all zero",
                  redir_valid, flush, br_cnt, taken_cnt, redir_pc);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fwd_branch();
      do_reset();
      br_valid = 1'b1; br_pc = 32'h0040_0010; br_imm = 16'h0003; bcres = 1'b1; redir_ready = 1'b1;
      step();
      br_valid = 1'b0;
      checks++;
      if (redir_valid !== 1'b1 || flush !== 1'b1 || redir_pc !== 32'h0040_0020) begin
         failures++;
         $display("FAIL fwd_redirect: valid=%b flush=%b pc=%h required 1 1 00400020", redir_valid, flush, redir_pc);
      end
      step();
      checks++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL fwd_after: valid=%b flush=%b br=%0d tk=%0d required 0 0 1 1", redir_valid, flush, br_cnt, taken_cnt);
      end
   endtask

   task automatic test_back_and_not_taken();
      do_reset();
      br_valid = 1'b1; br_pc = 32'h0040_0100; br_imm = 16'hFFFE; bcres = 1'b1; redir_ready = 1'b1;
      step();
      br_valid = 1'b0;
      checks++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h0040_00FC) begin
         failures++;
         $display("FAIL back_redirect: valid=%b pc=%h required 1 004000FC", redir_valid, redir_pc);
      end
      step();
      br_valid = 1'b1; br_pc = 32'h0040_0200; br_imm = 16'h0010; bcres = 1'b0;
      step();
      br_valid = 1'b0;
      checks++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || br_cnt !== 4'd2 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL not_taken: valid=%b flush=%b br=%0d tk=%0d required 0 0 2 1", redir_valid, flush, br_cnt, taken_cnt);
      end
   endtask

   task automatic test_jump();
      do_reset();
      br_valid = 1'b1; br_pc = 32'h1040_0000; is_jump = 1'b1; jidx = 26'h000_0100; bcres = 1'b0;
      br_imm = 16'h8000; redir_ready = 1'b1;
      step();
      br_valid = 1'b0; is_jump = 1'b0;
      checks++;
      if (redir_valid !== 1'b1 || flush !== 1'b1 || redir_pc !== 32'h1000_0400 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL jump: valid=%b flush=%b pc=%h tk=%0d required 1 1 10000400 1", redir_valid, flush, redir_pc, taken_cnt);
      end
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      br_valid = 1'b1; br_pc = 32'h0040_1000; br_imm = 16'h0001; bcres = 1'b1; redir_ready = 1'b0;
      step();
      // Keep a taken branch on the inputs; it is on the squashed path.
      br_pc = 32'h0040_2000; br_imm = 16'h0040;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) redir_ready = 1'b1;
         checks++;
         if (redir_valid !== 1'b1 || redir_pc !== 32'h0040_1008 || flush !== (c == 1)) begin
            failures++;
            $display("FAIL bp_hold_c%0d: valid=%b pc=%h flush=%b required 1 00401008 %b",
                     c, redir_valid, redir_pc, flush, (c == 1));
         end
         step();
      end
      br_valid = 1'b0;
      checks++;
      if (redir_valid !== 1'b0 || br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL bp_release: valid=%b br=%0d tk=%0d required 0 1 1", redir_valid, br_cnt, taken_cnt);
      end
      step();
      checks++;
      if (redir_valid !== 1'b0 || flush !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_reissue: valid=%b flush=%b required 0 0", redir_valid, flush);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      br_valid = 1'b1; br_pc = 32'h0040_0010; br_imm = 16'h0003; bcres = 1'b1; redir_ready = 1'b0;
      step();
      br_valid = 1'b0;
      checks++;
      if (redir_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre: valid=%b required 1", redir_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || br_cnt !== 4'd0 || taken_cnt !== 4'd0 || redir_pc !== '0) begin
         failures++;
         $display("FAIL rst_async: valid=%b flush=%b br=%0d tk=%0d pc=%h required all zero",
                  redir_valid, flush, br_cnt, taken_cnt, redir_pc);
      end
      #1 rst_n = 1'b1;
      redir_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (redir_valid !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_reissue_c%0d: valid=%b flush=%b required 0 0", c, redir_valid, flush);
         end
      end
   endtask

   task automatic test_back_to_back_wrap();
      do_reset();
      bcres = 1'b1; br_imm = 16'h0004; redir_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         br_valid = 1'b1; br_pc = 32'h0040_0000 + 32'(i * 16);
         step();
         br_valid = 1'b0;
         if (i == 15) begin
            checks++;
            if (br_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
               failures++;
               $display("FAIL wrap_zero: br=%0d tk=%0d required 0 0", br_cnt, taken_cnt);
            end
         end
         checks++;
         if (redir_valid !== 1'b1 || flush !== 1'b1 || redir_pc !== 32'h0040_0014 + 32'(i * 16)) begin
            failures++;
            $display("FAIL b2b_redirect_%0d: valid=%b flush=%b pc=%h required 1 1 %h",
                     i, redir_valid, flush, redir_pc, 32'h0040_0014 + 32'(i * 16));
         end
         step();
      end
      checks++;
      if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin
         failures++;
         $display("FAIL wrap_final: br=%0d tk=%0d required 1 1", br_cnt, taken_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fwd_branch();
      test_back_and_not_taken();
      test_jump();
      test_backpressure();
      test_reset_mid_wait();
      test_back_to_back_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Consumes the branch-condition result produced by the branch condition evaluator in the decode stage and turns resolved taken branches and jumps into a fetch redirect. Computes the target PC, holds it under a valid/ready handshake until fetch accepts it, and pulses a squash to the IF/ID register. Fetch predicts not-taken, so every taken branch and every jump is a redirect. No delay slot is implemented. Also keeps resolved-branch and taken-branch event counters for the processor's performance registers.

## Interface
- ADDR_W, 32: PC width; fixed at 32 for MIPS, parameterised only for the bench.
- CNT_W, 32: width of both event counters.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- br_valid  in  1  branch or jump in decode resolves this cycle
- br_pc  in  ADDR_W  PC of that instruction
- br_imm  in  16  I-type offset field, in words, signed
- bcres  in  1  condition result from the branch condition evaluator
- is_jump  in  1  unconditional J-type; bcres is ignored when high
- jidx  in  26  J-type index field
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  ADDR_W  redirect target; stable while redir_valid is high
- redir_ready  in  1  fetch accepts the redirect
- flush  out  1  one-cycle squash of IF/ID
- br_cnt  out  CNT_W  resolved branches and jumps accepted
- taken_cnt  out  CNT_W  redirects issued

## Operation
- pc4 = br_pc + 4, modulo 2^ADDR_W.
- Branch target = pc4 + (sign_extend(br_imm) << 2), modulo 2^ADDR_W.
- Jump target = {pc4[31:28], jidx, 2'b00}.
- take = br_valid & (is_jump | bcres).
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If br_valid: br_cnt increments.
  - If take: register the target into redir_pc, set redir_valid, pulse flush, increment taken_cnt, go to WAIT.
  - If br_valid and not take: no other effect.
- WAIT:
  - redir_valid stays high and redir_pc stays constant.
  - When redir_valid & redir_ready at a clock edge: redir_valid clears and the state returns to IDLE.
  - br_valid in WAIT, including the handshake cycle, belongs to the squashed path. It is ignored: no redirect and no count.
- Counters wrap modulo 2^CNT_W without saturation.
- Outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values while rst_n is low: state IDLE, redir_valid 0, redir_pc 0, flush 0, br_cnt 0, taken_cnt 0. Reset takes effect immediately without a clock edge.
- Resolve-to-redirect latency:
  - Taken branch sampled at edge N.
  - redir_valid and flush are high in cycle N+1.
  - Counters show their new values in cycle N+1.
- flush is high for exactly one cycle per redirect, regardless of how long redir_ready stays low.
- Minimum redirect occupancy is one cycle, when redir_ready is high in cycle N+1. The next branch can be accepted at edge N+2 at the earliest.
- redir_ready while redir_valid is low has no effect.
- Reset asserted in WAIT: the redirect is dropped and is not reissued after reset.

## Test plan
- Taken forward branch: br_pc=0x00400010, br_imm=0x0003, bcres=1, redir_ready=1 -> next cycle redir_valid=1, redir_pc=0x00400020, flush=1. One cycle later redir_valid=0, br_cnt=1, taken_cnt=1.
- Taken backward branch and not-taken branch:
  - br_pc=0x00400100, br_imm=0xFFFE, bcres=1 -> redir_pc=0x004000FC.
  - A following not-taken branch -> no redir_valid and no flush; br_cnt goes from 1 to 2; taken_cnt stays 1.
- Jump: br_pc=0x10400000, is_jump=1, jidx=0x0000100, bcres=0 -> redir_pc=0x10000400, flush=1.
- Backpressure: taken branch with redir_ready low for 3 cycles, and br_valid=1 with bcres=1 during those cycles:
  - redir_valid held for 4 cycles with redir_pc unchanged.
  - flush high only in the first cycle.
  - Counters advance only for the first branch.
- Reset mid-WAIT: rst_n low between edges while redir_valid=1 -> redir_valid, flush and both counters are 0 immediately. After release, no redirect appears until a new taken branch.
- Wrap with CNT_W=4: 17 consecutive taken branches, each accepted immediately -> both counters read 1.
